// File: rtl/mbist_op_seq.sv
// mbist_op_seq - march-element operation sequencer for the MBIST engine.
//
// Steps through up to BIST_OP_MAX operation slots of one march element.
// Each slot carries a read, write and invert control. NOP slots (no read
// and no write) are skipped. Only slots below the latched operation count
// are considered. A valid/step handshake hands one operation at a time to
// the address/data generators. 'wrap' flags that the element restarted at
// its first slot. The one-hot slot pointer is part of the scan chain.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   scan_shift, sdi     shift the pointer register toward bit 0, sdi in at top
//   sdo                 scan out, always op_sel[0]
//   start               latch stimulus/op_cnt and begin (IDLE only)
//   stop                abort, return to IDLE with pointer on slot 0
//   step                consumer accepted the current operation
//   stimulus            per slot {write, read, invert}; top three bits are
//                       {updown, reverse, repeatflag}
//   op_cnt              number of active slots counted from slot 0
//   op_valid            an operation is being presented (RUN)
//   op_read/write/invert  controls of the current operation
//   op_updown/reverse/repeatflag  element-wide flags from latched stimulus
//   last_op             current operation is the last non-NOP active slot
//   wrap                one-cycle pulse after a step accepted on last_op
//   err_nop             one-cycle pulse after a start with nothing to run
module mbist_op_seq #(
  parameter int BIST_OP_MAX = 8,
  parameter int BIST_CNT_WD = $clog2(BIST_OP_MAX + 1),
  parameter int BIST_STI_WD = 3 * BIST_OP_MAX + 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_shift,
  input  logic                   sdi,
  output logic                   sdo,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic [BIST_STI_WD-1:0] stimulus,
  input  logic [BIST_CNT_WD-1:0] op_cnt,
  output logic                   op_valid,
  output logic                   op_read,
  output logic                   op_write,
  output logic                   op_invert,
  output logic                   op_updown,
  output logic                   op_reverse,
  output logic                   op_repeatflag,
  output logic                   last_op,
  output logic                   wrap,
  output logic                   err_nop
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [BIST_CNT_WD-1:0] CNT_MAX = BIST_CNT_WD'(BIST_OP_MAX);
  localparam logic [BIST_OP_MAX-1:0] SEL_SLOT0 = BIST_OP_MAX'(1);

  state_t                 state_reg;
  logic [BIST_OP_MAX-1:0] op_sel_reg;
  logic [BIST_STI_WD-1:0] sti_reg;
  logic [BIST_CNT_WD-1:0] cnt_reg;
  logic                   wrap_reg;
  logic                   err_reg;

  logic [BIST_CNT_WD-1:0] eff_cnt;
  logic [BIST_OP_MAX-1:0] start_mask;   // runnable slots of the incoming stimulus
  logic [BIST_OP_MAX-1:0] run_mask;     // runnable slots of the latched stimulus
  logic [BIST_OP_MAX-1:0] sel_below;    // bit i set when the pointer sits below slot i
  logic [BIST_OP_MAX-1:0] higher_mask;  // runnable slots above the current one
  logic [BIST_OP_MAX-1:0] read_bits;
  logic [BIST_OP_MAX-1:0] write_bits;
  logic [BIST_OP_MAX-1:0] invert_bits;
  logic [BIST_OP_MAX-1:0] first_start_next;
  logic [BIST_OP_MAX-1:0] first_run_next;
  logic [BIST_OP_MAX-1:0] higher_next;
  logic                   is_last;
  logic                   run_active;

  // Isolates the lowest set bit: picking the lowest runnable slot in a mask
  // is what lets NOP slots be skipped within one cycle.
  function automatic logic [BIST_OP_MAX-1:0] lowest_one(input logic [BIST_OP_MAX-1:0] x);
    return x & (~x + BIST_OP_MAX'(1));
  endfunction

  assign eff_cnt = (op_cnt > CNT_MAX) ? CNT_MAX : op_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < BIST_OP_MAX; gi++) begin : g_slot
      localparam logic [BIST_CNT_WD-1:0] SLOT_IDX = BIST_CNT_WD'(gi);

      assign start_mask[gi] = (SLOT_IDX < eff_cnt) &&
                              (stimulus[3*gi+1] || stimulus[3*gi+2]);
      assign run_mask[gi]   = (SLOT_IDX < cnt_reg) &&
                              (sti_reg[3*gi+1] || sti_reg[3*gi+2]);

      assign invert_bits[gi] = sti_reg[3*gi];
      assign read_bits[gi]   = sti_reg[3*gi+1];
      assign write_bits[gi]  = sti_reg[3*gi+2];

      if (gi == 0) begin : g_first
        assign sel_below[gi] = 1'b0;
      end else begin : g_rest
        assign sel_below[gi] = |op_sel_reg[gi-1:0];
      end
    end
  endgenerate

  assign higher_mask      = run_mask & sel_below;
  assign is_last          = (higher_mask == '0);
  assign first_start_next = lowest_one(start_mask);
  assign first_run_next   = lowest_one(run_mask);
  assign higher_next      = lowest_one(higher_mask);

  assign run_active = (state_reg == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      op_sel_reg <= SEL_SLOT0;
      sti_reg    <= '0;
      cnt_reg    <= '0;
      wrap_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (scan_shift) begin
        op_sel_reg <= {sdi, op_sel_reg[BIST_OP_MAX-1:1]};
      end else if (stop) begin
        state_reg  <= ST_IDLE;
        op_sel_reg <= SEL_SLOT0;
      end else if (start && !run_active) begin
        sti_reg <= stimulus;
        cnt_reg <= eff_cnt;
        if (|start_mask) begin
          op_sel_reg <= first_start_next;
          state_reg  <= ST_RUN;
        end else begin
          // Nothing runnable: stay put and report it; pointer is left alone.
          err_reg <= 1'b1;
        end
      end else if (step && run_active) begin
        if (is_last) begin
          op_sel_reg <= first_run_next;
          wrap_reg   <= 1'b1;
        end else begin
          op_sel_reg <= higher_next;
        end
      end
    end
  end

  // In RUN the pointer always rests on a runnable slot, so the controls are
  // simply the selected slot's bits.
  assign op_valid      = run_active;
  assign op_read       = run_active && |(op_sel_reg & read_bits);
  assign op_write      = run_active && |(op_sel_reg & write_bits);
  assign op_invert     = run_active && |(op_sel_reg & invert_bits);
  assign last_op       = run_active && is_last;
  assign op_updown     = sti_reg[BIST_STI_WD-1];
  assign op_reverse    = sti_reg[BIST_STI_WD-2];
  assign op_repeatflag = sti_reg[BIST_STI_WD-3];
  assign wrap          = wrap_reg;
  assign err_nop       = err_reg;
  assign sdo           = op_sel_reg[0];

endmodule

// File: tb/tb_mbist_op_seq.sv
// Testbench for mbist_op_seq: directed stimulus, a slot-index behavioural
// model checked against the DUT on every falling edge, plus literal checks.
module tb_mbist_op_seq;

  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX + 1);
  localparam int SW  = 3 * MAX + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scan_shift, sdi, start, stop, step;
  logic [SW-1:0] stimulus;
  logic [CW-1:0] op_cnt;
  logic sdo, op_valid, op_read, op_write, op_invert;
  logic op_updown, op_reverse, op_repeatflag, last_op, wrap, err_nop;

  int n_vec = 0;
  int n_bad = 0;

  mbist_op_seq #(.BIST_OP_MAX(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .scan_shift(scan_shift), .sdi(sdi), .sdo(sdo),
    .start(start), .stop(stop), .step(step), .stimulus(stimulus), .op_cnt(op_cnt),
    .op_valid(op_valid), .op_read(op_read), .op_write(op_write), .op_invert(op_invert),
    .op_updown(op_updown), .op_reverse(op_reverse), .op_repeatflag(op_repeatflag),
    .last_op(last_op), .wrap(wrap), .err_nop(err_nop)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (slot indices, not pointers) -------
  logic          m_run, m_wrap, m_err;
  logic [SW-1:0] m_sti;
  logic [MAX-1:0] m_chain;  // pointer as seen by the scan chain while IDLE
  int            m_cnt, m_slot;

  function automatic int clamp(input int c);
    return (c > MAX) ? MAX : c;
  endfunction

  function automatic bit runnable(input logic [SW-1:0] s, input int c, input int i);
    return (i < c) && (s[3*i+1] || s[3*i+2]);
  endfunction

  function automatic int first_act(input logic [SW-1:0] s, input int c);
    for (int i = 0; i < MAX; i++) if (runnable(s, c, i)) return i;
    return -1;
  endfunction

  function automatic int next_act(input logic [SW-1:0] s, input int c, input int cur);
    for (int i = cur + 1; i < MAX; i++) if (runnable(s, c, i)) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_wrap <= 1'b0; m_err <= 1'b0;
      m_sti <= '0; m_cnt <= 0; m_slot <= 0; m_chain <= MAX'(1);
    end else begin
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
      if (scan_shift) begin
        m_chain <= {sdi, m_chain[MAX-1:1]};
      end else if (stop) begin
        m_run <= 1'b0; m_chain <= MAX'(1);
      end else if (start && !m_run) begin
        m_sti <= stimulus;
        m_cnt <= clamp(int'(op_cnt));
        if (first_act(stimulus, clamp(int'(op_cnt))) < 0) m_err <= 1'b1;
        else begin
          m_run  <= 1'b1;
          m_slot <= first_act(stimulus, clamp(int'(op_cnt)));
        end
      end else if (step && m_run) begin
        if (next_act(m_sti, m_cnt, m_slot) < 0) begin
          m_slot <= first_act(m_sti, m_cnt);
          m_wrap <= 1'b1;
        end else begin
          m_slot <= next_act(m_sti, m_cnt, m_slot);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("m.op_valid", op_valid, m_run);
    chk("m.op_read",  op_read,  m_run && m_sti[3*m_slot+1]);
    chk("m.op_write", op_write, m_run && m_sti[3*m_slot+2]);
    chk("m.op_invert", op_invert, m_run && m_sti[3*m_slot]);
    chk("m.last_op", last_op, m_run && (next_act(m_sti, m_cnt, m_slot) < 0));
    chk("m.wrap", wrap, m_wrap);
    chk("m.err_nop", err_nop, m_err);
    chk("m.sdo", sdo, m_run ? (m_slot == 0) : m_chain[0]);
    chk("m.op_updown", op_updown, m_sti[SW-1]);
    chk("m.op_reverse", op_reverse, m_sti[SW-2]);
    chk("m.op_repeatflag", op_repeatflag, m_sti[SW-3]);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic slot(input int i, input bit w, input bit r, input bit v);
    stimulus[3*i+2] = w;
    stimulus[3*i+1] = r;
    stimulus[3*i]   = v;
  endtask

  task automatic note(input string what);
    $display("[%0t] %s: valid=%b r=%b w=%b i=%b last=%b wrap=%b err=%b sdo=%b",
             $time, what, op_valid, op_read, op_write, op_invert, last_op, wrap, err_nop, sdo);
  endtask

  logic [7:0] pat;

  initial begin
    rst_n = 1'b1; scan_shift = 0; sdi = 0; start = 0; stop = 0; step = 0;
    stimulus = '0; op_cnt = '0; pat = 8'hA5;
    #1 rst_n = 1'b0;
    cyc(); cyc();
    note("reset");
    chk("rst.op_valid", op_valid, 1'b0);
    chk("rst.sdo", sdo, 1'b1);
    chk("rst.wrap", wrap, 1'b0);
    chk("rst.err_nop", err_nop, 1'b0);
    rst_n = 1'b1;
    cyc();

    // W0, R0, W1 with updown/repeatflag set.
    stimulus = '0; slot(0, 1, 0, 0); slot(1, 0, 1, 0); slot(2, 1, 0, 1);
    stimulus[SW-1] = 1'b1; stimulus[SW-3] = 1'b1;
    op_cnt = CW'(3); start = 1; cyc(); start = 0;
    note("W0");
    chk("t1.w0.valid", op_valid, 1'b1); chk("t1.w0.write", op_write, 1'b1);
    chk("t1.w0.read", op_read, 1'b0);   chk("t1.w0.last", last_op, 1'b0);
    chk("t1.updown", op_updown, 1'b1);  chk("t1.reverse", op_reverse, 1'b0);
    chk("t1.repeat", op_repeatflag, 1'b1);
    step = 1; cyc(); note("R0");
    chk("t1.r0.read", op_read, 1'b1); chk("t1.r0.write", op_write, 1'b0);
    chk("t1.r0.sdo", sdo, 1'b0);
    cyc(); note("W1");
    chk("t1.w1.write", op_write, 1'b1); chk("t1.w1.invert", op_invert, 1'b1);
    chk("t1.w1.last", last_op, 1'b1);   chk("t1.w1.wrap", wrap, 1'b0);
    cyc(); note("W0 again");
    chk("t1.wrap.pulse", wrap, 1'b1); chk("t1.wrap.write", op_write, 1'b1);
    chk("t1.wrap.invert", op_invert, 1'b0); chk("t1.wrap.sdo", sdo, 1'b1);
    step = 0; cyc(); note("hold");
    chk("t1.wrap.once", wrap, 1'b0);
    stimulus = '0; start = 1; cyc(); start = 0; note("start in RUN");
    chk("t1.start_ignored", op_write, 1'b1);

    // NOP skipping: slots 0, 2, 4 runnable, 1 and 3 NOP.
    stop = 1; cyc(); stop = 0; note("stop");
    chk("t2.stop.valid", op_valid, 1'b0);
    stimulus = '0; slot(0, 1, 0, 0); slot(1, 0, 0, 1); slot(2, 0, 1, 0); slot(4, 1, 0, 1);
    op_cnt = CW'(5); start = 1; cyc(); start = 0; step = 1; note("slot0");
    chk("t2.s0.sdo", sdo, 1'b1);
    cyc(); note("slot2");
    chk("t2.s2.read", op_read, 1'b1); chk("t2.s2.last", last_op, 1'b0);
    cyc(); step = 0; note("slot4");
    chk("t2.s4.invert", op_invert, 1'b1); chk("t2.s4.last", last_op, 1'b1);
    cyc();

    // No runnable slot: all active slots NOP, then op_cnt=0.
    stop = 1; cyc(); stop = 0;
    stimulus = '0; slot(3, 1, 0, 0); op_cnt = CW'(3);
    start = 1; cyc(); start = 0; note("all NOP");
    chk("t3.err", err_nop, 1'b1); chk("t3.valid", op_valid, 1'b0);
    cyc(); chk("t3.err_once", err_nop, 1'b0); chk("t3.valid2", op_valid, 1'b0);
    for (int i = 0; i < MAX; i++) slot(i, 0, 1, 0);
    op_cnt = '0; start = 1; cyc(); start = 0; note("op_cnt=0");
    chk("t3.cnt0.err", err_nop, 1'b1); chk("t3.cnt0.valid", op_valid, 1'b0);
    cyc(); chk("t3.cnt0.err_once", err_nop, 1'b0);

    // op_cnt above BIST_OP_MAX is clamped: slot 7 is last.
    op_cnt = CW'(12); start = 1; cyc(); start = 0; step = 1;
    repeat (MAX - 1) cyc();
    step = 0; note("slot7");
    chk("t4.last", last_op, 1'b1); chk("t4.valid", op_valid, 1'b1);
    stop = 1; start = 1; cyc(); stop = 0; start = 0; note("stop+start");
    chk("t4.stopwins", op_valid, 1'b0);
    cyc(); chk("t4.idle", op_valid, 1'b0);

    // Scan: shift A5 in, original pointer comes out, then the pattern.
    scan_shift = 1;
    for (int i = 0; i < MAX; i++) begin
      sdi = pat[i];
      chk("t5.sdo.orig", sdo, (i == 0));
      cyc();
    end
    note("scanned in");
    for (int i = 0; i < MAX; i++) begin
      sdi = 1'b0;
      chk("t5.sdo.pat", sdo, pat[i]);
      cyc();
    end
    scan_shift = 0;
    stimulus = '0; slot(2, 0, 1, 0); op_cnt = CW'(4);
    start = 1; cyc(); start = 0; note("start after scan");
    chk("t5.valid", op_valid, 1'b1); chk("t5.read", op_read, 1'b1);
    chk("t5.sdo", sdo, 1'b0); chk("t5.last", last_op, 1'b1);

    // Asynchronous reset in the middle of RUN.
    step = 1; cyc(); step = 0;
    #1 rst_n = 1'b0;
    #1 note("async reset");
    chk("t6.valid", op_valid, 1'b0); chk("t6.sdo", sdo, 1'b1);
    chk("t6.wrap", wrap, 1'b0); chk("t6.read", op_read, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mbist_op_seq.md
Name: mbist_op_seq

Overview:
- Parametrised successor to the fixed-size MBIST operation selector.
- Sequences the read/write/invert operations of one march element.
- Supports up to BIST_OP_MAX slots, a run-time operation count and automatic skipping of NOP slots.
- Uses a valid/step handshake to the address generator and flags wrap-around; the one-hot pointer stays on the scan chain. It sits between the stimulus register and the MBIST address/data generators.

Parameters:
- BIST_OP_MAX, 8, number of operation slots (2..16).
- BIST_CNT_WD, $clog2(BIST_OP_MAX+1), width of op_cnt.
- BIST_STI_WD, 3*BIST_OP_MAX+3, stimulus width (derived; do not override).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- scan_shift  input  1  scan shift enable; shifts pointer register
- sdi  input  1  scan data in
- sdo  output  1  scan data out = op_sel[0]
- start  input  1  latch stimulus/op_cnt, begin sequence
- stop  input  1  end sequence, return to IDLE
- step  input  1  advance to next operation (consumer accepted current op)
- stimulus  input  BIST_STI_WD  slot i: [3i]=invert, [3i+1]=read, [3i+2]=write; [top]=updown, [top-1]=reverse, [top-2]=repeatflag
- op_cnt  input  BIST_CNT_WD  number of active slots, counted from slot 0
- op_valid  output  1  current op valid (RUN state)
- op_read, op_write, op_invert  output  1 each  current op controls, 0 when !op_valid
- op_updown, op_reverse, op_repeatflag  output  1 each  from latched stimulus
- last_op  output  1  current op is last non-NOP active slot (qualified by op_valid)
- wrap  output  1  one-cycle pulse: step accepted on last_op, pointer wrapped
- err_nop  output  1  one-cycle pulse: start rejected, no non-NOP active slot

Behaviour:
- Reset: state=IDLE; op_sel=one-hot slot 0; sti_q=0; cnt_q=0; all outputs 0 except sdo=op_sel[0]=1.
- NOP slot: read=0 and write=0 (invert ignored). Active slot: index < eff_cnt.
- eff_cnt = min(op_cnt, BIST_OP_MAX).
- Priority each cycle: scan_shift > stop > start > step.
- scan_shift: op_sel <= {sdi, op_sel[MAX-1:1]}; state, sti_q, cnt_q unchanged. Allowed in IDLE only; behaviour in RUN is undefined, not checked.
- IDLE + start:
  - sti_q <= stimulus, cnt_q <= eff_cnt.
  - If some active non-NOP slot exists: op_sel <= one-hot lowest such slot, state <= RUN; op_valid=1 the next cycle (latency 1).
  - Else (including eff_cnt=0): stay IDLE, err_nop=1 for one cycle.
- RUN:
  - Outputs are combinational from op_sel and sti_q.
  - step with !last_op: op_sel <= next higher active non-NOP slot; NOP slots are skipped in the same cycle, no bubble.
  - step with last_op: op_sel <= lowest active non-NOP slot, wrap=1 that cycle (registered pulse visible next cycle).
  - Single active non-NOP slot: last_op=1 permanently; each step pulses wrap.
  - No step: hold op and outputs.
- stop (any state): state <= IDLE, op_sel <= slot 0 one-hot, sti_q retained. op_valid=0 next cycle. stop+start same cycle: stop wins.
- start in RUN: ignored (only stop leaves RUN).
- stimulus/op_cnt changes after start: no effect until next start.
- op_updown/op_reverse/op_repeatflag are driven from sti_q in all states.
- Async reset mid-RUN: immediate return to reset values.

Test Plan:
- Reset → op_valid=0, sdo=1, wrap=0, err_nop=0; op_sel one-hot slot 0.
- op_cnt=3; slots 0=W0 (write=1), 1=R0 (read=1), 2=W1 (write=1, invert=1); start; step every cycle.
  - Ops W0, R0, W1 (last_op=1), W0; wrap pulses once after W1 accepted.
- op_cnt=5; slots 1 and 3 NOP; start; step.
  - Sequence slots 0, 2, 4 with no bubble cycles; last_op on slot 4.
- Start with all active slots NOP, and again with op_cnt=0.
  - err_nop=1 for exactly one cycle; op_valid stays 0.
- op_cnt=12 with BIST_OP_MAX=8 → clamped; slot 7 is last_op.
  - stop+start in the same cycle → remains IDLE.
- In IDLE, scan_shift for BIST_OP_MAX cycles with sdi pattern 8'hA5.
  - sdo returns original pointer bits 1,0,0,...; pattern observed after BIST_OP_MAX shifts.
  - Next start reinitialises to first active slot.
